// File: rtl/distr_arith_unit_pkg.sv
// Shared constants for the bit-serial distributed-arithmetic FIR engine.
package distr_arith_unit_pkg;
  localparam int NTAPS      = 64;
  localparam int NGROUPS    = 8;
  localparam int GROUP_TAPS = 8;
  localparam int SLICES     = 16;
  localparam int SAMPLE_W   = 16;
  localparam int SUM_W      = 32;
  localparam int IDX_W      = 4;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLICES - 1);
endpackage

// File: rtl/distr_arith_unit_if.sv
// Slice inputs and filter outputs of the DA engine, plus the slice index for debug.
// valid is a one-cycle strobe with no ready: the consumer must take sum when valid is high.
interface distr_arith_unit_if;
  logic                                      first;
  logic [7:0]                                x1_bit;
  logic [7:0]                                x2_bit;
  logic [7:0]                                x3_bit;
  logic [7:0]                                x4_bit;
  logic [7:0]                                x5_bit;
  logic [7:0]                                x6_bit;
  logic [7:0]                                x7_bit;
  logic [7:0]                                x8_bit;
  logic [distr_arith_unit_pkg::SUM_W-1:0]    sum;
  logic                                      valid;
  logic [distr_arith_unit_pkg::IDX_W-1:0]    idx;

  modport master (
    output first, x1_bit, x2_bit, x3_bit, x4_bit, x5_bit, x6_bit, x7_bit, x8_bit,
    input  sum, valid, idx
  );
  modport slave (
    input  first, x1_bit, x2_bit, x3_bit, x4_bit, x5_bit, x6_bit, x7_bit, x8_bit,
    output sum, valid, idx
  );
endinterface

// File: rtl/distr_arith_unit_lut8.sv
// Eight-tap DA group: signed sum of the coefficients whose slice bit is set.
module da_lut8
  import distr_arith_unit_pkg::*;
#(
  parameter int COEF_W = 16
) (
  input  logic [GROUP_TAPS-1:0]        bits,
  input  logic [GROUP_TAPS*COEF_W-1:0] coefs,
  output logic [COEF_W+2:0]            psum
);

  // Coefficient slot i belongs to the tap driven on bits[7-i] (bit 7 is the newest tap).
  always_comb begin
    psum = '0;
    for (int i = 0; i < GROUP_TAPS; i++) begin
      if (bits[GROUP_TAPS-1-i]) begin
        psum = psum + {{3{coefs[i*COEF_W+COEF_W-1]}}, coefs[i*COEF_W +: COEF_W]};
      end
    end
  end

endmodule

// File: rtl/distr_arith_unit.sv
// Bit-serial DA engine: per-slice partial sum, shift-accumulate of 16 slices, output register.
module distr_arith_unit
  import distr_arith_unit_pkg::*;
#(
  parameter int                        COEF_W = 16,
  parameter logic [NTAPS*COEF_W-1:0]   COEFS  = {NTAPS{16'h0001}}
) (
  input  logic               clk,
  input  logic               areset_n,
  distr_arith_unit_if.slave  bus
);

  localparam int PW = COEF_W + 6;

  logic [GROUP_TAPS-1:0] grp_bits [NGROUPS];
  logic [COEF_W+2:0]     grp_sum  [NGROUPS];
  logic [PW-1:0]         p;
  logic [SUM_W-1:0]      p_ext;
  logic [SUM_W-1:0]      shifted;
  logic [IDX_W-1:0]      cur_idx;
  logic [IDX_W-1:0]      idx_q;
  logic [SUM_W-1:0]      acc_q;
  logic [SUM_W-1:0]      sum_q;
  logic                  valid_q;

  assign grp_bits[0] = bus.x1_bit;
  assign grp_bits[1] = bus.x2_bit;
  assign grp_bits[2] = bus.x3_bit;
  assign grp_bits[3] = bus.x4_bit;
  assign grp_bits[4] = bus.x5_bit;
  assign grp_bits[5] = bus.x6_bit;
  assign grp_bits[6] = bus.x7_bit;
  assign grp_bits[7] = bus.x8_bit;

  for (genvar g = 0; g < NGROUPS; g++) begin : g_lut
    da_lut8 #(.COEF_W(COEF_W)) u_lut (
      .bits  (grp_bits[g]),
      .coefs (COEFS[g*GROUP_TAPS*COEF_W +: GROUP_TAPS*COEF_W]),
      .psum  (grp_sum[g])
    );
  end

  always_comb begin
    p = '0;
    for (int g = 0; g < NGROUPS; g++) begin
      p = p + {{3{grp_sum[g][COEF_W+2]}}, grp_sum[g]};
    end
  end

  assign p_ext   = {{(SUM_W-PW){p[PW-1]}}, p};
  assign cur_idx = bus.first ? '0 : idx_q + 1'b1;
  assign shifted = p_ext << cur_idx;

  // Slice 15 carries the sample sign bit, so its weighted partial sum is subtracted.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      idx_q   <= IDX_LAST;
      acc_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= cur_idx;
      valid_q <= (cur_idx == IDX_LAST);
      if (cur_idx == '0) begin
        acc_q <= p_ext;
      end else if (cur_idx == IDX_LAST) begin
        sum_q <= acc_q - shifted;
      end else begin
        acc_q <= acc_q + shifted;
      end
    end
  end

  assign bus.sum   = sum_q;
  assign bus.valid = valid_q;
  assign bus.idx   = idx_q;

endmodule

// File: tb/tb_distr_arith_unit.sv
// Self-checking bench for distr_arith_unit: unit coefficients (dut_a) and h[t]=t (dut_b).
module tb_distr_arith_unit;

  function automatic logic [64*16-1:0] ramp_coefs();
    logic [64*16-1:0] r;
    for (int t = 0; t < 64; t++) r[t*16 +: 16] = 16'(t);
    return r;
  endfunction

  localparam logic [64*16-1:0] RAMP = ramp_coefs();

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic areset_n;
  always #5 clk = ~clk;

  distr_arith_unit_if ifa ();
  distr_arith_unit_if ifb ();

  distr_arith_unit dut_a (.clk(clk), .areset_n(areset_n), .bus(ifa));
  distr_arith_unit #(.COEF_W(16), .COEFS(RAMP)) dut_b (.clk(clk), .areset_n(areset_n), .bus(ifb));

  // ---------------- scoreboard ----------------
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  logic [31:0] last_a = '0;
  int          n_cmp  = 0;
  int          n_bad  = 0;
  logic [15:0] samp [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: the filter output is the plain dot product of the signed samples with h.
  function automatic logic [31:0] model(input bit ramp);
    longint total = 0;
    for (int t = 0; t < 64; t++)
      total += longint'($signed(samp[t])) * (ramp ? longint'(t) : 64'sd1);
    return total[31:0];
  endfunction

  always @(negedge clk) begin
    if (ifa.valid) begin
      if (exp_a_q.size() == 0) check("spurious_valid_a", 32'd1, 32'd0);
      else begin
        last_a = exp_a_q.pop_front();
        check("sum_a", ifa.sum, last_a);
      end
    end
    if (ifb.valid) begin
      if (exp_b_q.size() == 0) check("spurious_valid_b", 32'd1, 32'd0);
      else check("sum_b", ifb.sum, exp_b_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_slice(input int j, input logic f);
    logic [63:0] xv;
    for (int t = 0; t < 64; t++) xv[63-t] = samp[t][j];
    ifa.first = f;           ifb.first = f;
    ifa.x1_bit = xv[63:56];  ifb.x1_bit = xv[63:56];
    ifa.x2_bit = xv[55:48];  ifb.x2_bit = xv[55:48];
    ifa.x3_bit = xv[47:40];  ifb.x3_bit = xv[47:40];
    ifa.x4_bit = xv[39:32];  ifb.x4_bit = xv[39:32];
    ifa.x5_bit = xv[31:24];  ifb.x5_bit = xv[31:24];
    ifa.x6_bit = xv[23:16];  ifb.x6_bit = xv[23:16];
    ifa.x7_bit = xv[15:8];   ifb.x7_bit = xv[15:8];
    ifa.x8_bit = xv[7:0];    ifb.x8_bit = xv[7:0];
    @(negedge clk);
  endtask

  task automatic drive_word(input int nslices);
    if (nslices == 16) begin
      exp_a_q.push_back(model(1'b0));
      exp_b_q.push_back(model(1'b1));
    end
    for (int j = 0; j < nslices; j++) drive_slice(j, j == 0);
  endtask

  task automatic fill(input logic [15:0] v);
    for (int t = 0; t < 64; t++) samp[t] = v;
  endtask

  task automatic fill_random();
    for (int t = 0; t < 64; t++)
      samp[t] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    areset_n = 1'b0;
    fill(16'h0000);
    drive_slice(0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_sum_a", ifa.sum, 32'd0);
    check("rst_valid_a", {31'd0, ifa.valid}, 32'd0);
    check("rst_idx_a", {28'd0, ifa.idx}, 32'd15);
    check("rst_sum_b", ifb.sum, 32'd0);

    // Out of reset with first low, the first cycle counts as slice 0.
    exp_a_q.push_back(32'd0);
    exp_b_q.push_back(32'd0);
    areset_n = 1'b1;
    for (int j = 0; j < 15; j++) drive_slice(j, 1'b0);
    check("no_early_valid", {31'd0, ifa.valid}, 32'd0);
    drive_slice(15, 1'b0);

    fill(16'h0001); drive_word(16);
    fill(16'hFFFF); drive_word(16);
    fill(16'h7FFF); drive_word(16);
    fill(16'h0000); samp[0]  = 16'h8000; drive_word(16);
    fill(16'h0000); samp[63] = 16'h7FFF; drive_word(16);
    fill(16'h0000); samp[5]  = 16'h0003; drive_word(16);

    for (int w = 0; w < 20; w++) begin
      fill_random();
      drive_word(16);
    end

    // Abort at idx 7: no output, sum holds, next word still correct.
    fill_random();
    drive_word(7);
    check("abort_sum_hold", ifa.sum, last_a);
    check("abort_no_valid", {31'd0, ifa.valid}, 32'd0);
    fill_random();
    drive_word(16);

    // Asynchronous reset in the middle of a word.
    fill(16'h1234);
    drive_word(5);
    areset_n = 1'b0;
    #1;
    check("midrst_sum_a", ifa.sum, 32'd0);
    check("midrst_valid_a", {31'd0, ifa.valid}, 32'd0);
    check("midrst_idx_a", {28'd0, ifa.idx}, 32'd15);
    check("midrst_sum_b", ifb.sum, 32'd0);
    @(negedge clk);
    areset_n = 1'b1;
    fill_random();
    drive_word(16);

    fill(16'h0000);
    drive_slice(0, 1'b1);
    repeat (2) @(negedge clk);
    check("leftover_a", 32'(exp_a_q.size()), 32'd0);
    check("leftover_b", 32'(exp_b_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
